// File: rtl/dtw_ref_pkg.sv
// dtw_ref_pkg: shared FSM state and operating-mode encodings for the DTW reference memory
package dtw_ref_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2, ERR = 2'd3} state_t;
    localparam logic MODE_DTW_READ = 1'b0;
    localparam logic MODE_LOAD_REF = 1'b1;
endpackage

// File: rtl/dtw_core_ref_bank.sv
// dtw_core_ref_bank: one reference bank, single write port and registered read port
module dtw_core_ref_bank #(
    parameter int DATA_WIDTH       = 16,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter bit REF_INIT         = 1'b0
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [REFMEM_PTR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    input  logic [REFMEM_PTR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
);
    localparam int DEPTH = 1 << REFMEM_PTR_WIDTH;

    // Memory array itself is never reset; only the read register is.
    if (REF_INIT) begin : g_init
        logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
        always_ff @(posedge clk_in)
            if (wr_en) mem[wr_addr] <= wr_data;
        always_ff @(posedge clk_in or negedge rst_n)
            if (!rst_n) rd_data <= '0;
            else if (rd_en) rd_data <= mem[rd_addr];
    end else begin : g_noinit
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk_in)
            if (wr_en) mem[wr_addr] <= wr_data;
        always_ff @(posedge clk_in or negedge rst_n)
            if (!rst_n) rd_data <= '0;
            else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/dtw_core_ref_multi.sv
// dtw_core_ref_multi: loads a reference sequence from a FIFO into NUM_PORTS mirrored
// banks, then serves independent single-cycle-latency DTW reads on every port.
module dtw_core_ref_multi
    import dtw_ref_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int NUM_PORTS        = 4,
    parameter bit REF_INIT         = 1'b0
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  rs_in,
    input  logic                                  op_mode_in,
    input  logic [ADDR_WIDTH-1:0]                 ref_len_in,
    output logic                                  busy_out,
    output logic                                  ref_load_done_out,
    output logic                                  ref_len_err_out,
    output logic                                  src_fifo_clear_out,
    output logic                                  src_fifo_rden_out,
    input  logic                                  src_fifo_empty_in,
    input  logic [DATA_WIDTH-1:0]                 src_fifo_data_in,
    input  logic [NUM_PORTS-1:0]                  ref_rden_in,
    input  logic [NUM_PORTS*REFMEM_PTR_WIDTH-1:0] ref_addr_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]       ref_data_out,
    output logic [NUM_PORTS-1:0]                  ref_valid_out,
    output logic [1:0]                            dbg_state,
    output logic [ADDR_WIDTH-1:0]                 dbg_load_cnt
);
    localparam logic [63:0] DEPTH = 64'd1 << REFMEM_PTR_WIDTH;

    logic [1:0]                  rst_sync;
    logic                        rst_n;
    state_t                      state;
    logic [REFMEM_PTR_WIDTH:0]   cnt;
    logic                        len_bad;
    logic                        last;
    logic                        we;

    // Assert asynchronously, release only after two clk_in edges.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    assign len_bad            = ref_len_in == '0 || 64'(ref_len_in) > DEPTH;
    assign last               = 64'(cnt) == 64'(ref_len_in) - 64'd1;
    assign src_fifo_rden_out  = state == LOAD && !src_fifo_empty_in && 64'(cnt) < 64'(ref_len_in);
    assign we                 = src_fifo_rden_out && rs_in;
    assign busy_out           = state != IDLE;
    assign src_fifo_clear_out = state == IDLE || state == ERR;
    assign dbg_state          = state;
    assign dbg_load_cnt       = ADDR_WIDTH'(cnt);

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            ref_load_done_out <= 1'b0;
            ref_len_err_out   <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (rs_in && op_mode_in == MODE_LOAD_REF) begin
                        if (len_bad) begin
                            state           <= ERR;
                            ref_len_err_out <= 1'b1;
                        end else begin
                            state             <= LOAD;
                            ref_load_done_out <= 1'b0;
                            cnt               <= '0;
                        end
                    end else if (rs_in && op_mode_in == MODE_DTW_READ && ref_load_done_out)
                        state <= READ;
                LOAD:
                    if (!rs_in) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (we) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state             <= IDLE;
                            ref_load_done_out <= 1'b1;
                        end
                    end
                READ:
                    if (!rs_in || op_mode_in == MODE_LOAD_REF) state <= IDLE;
                ERR:
                    if (!rs_in) begin
                        state           <= IDLE;
                        ref_len_err_out <= 1'b0;
                    end
            endcase
        end

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) ref_valid_out <= '0;
        else ref_valid_out <= ref_rden_in & {NUM_PORTS{state == READ}};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bank
        dtw_core_ref_bank #(
            .DATA_WIDTH      (DATA_WIDTH),
            .REFMEM_PTR_WIDTH(REFMEM_PTR_WIDTH),
            .REF_INIT        (REF_INIT)
        ) u_bank (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .wr_en  (we),
            .wr_addr(cnt[REFMEM_PTR_WIDTH-1:0]),
            .wr_data(src_fifo_data_in),
            .rd_en  (ref_rden_in[i] && state == READ),
            .rd_addr(ref_addr_in[i*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH]),
            .rd_data(ref_data_out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_dtw_core_ref_multi.sv
// tb_dtw_core_ref_multi: directed vector table plus randomized load/read against a
// behavioural memory image of the reference banks.
module tb_dtw_core_ref_multi;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int PW = 6;
    localparam int NP = 4;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           rs_in;
    logic           op_mode_in;
    logic [AW-1:0]  ref_len_in;
    logic           busy_out;
    logic           ref_load_done_out;
    logic           ref_len_err_out;
    logic           src_fifo_clear_out;
    logic           src_fifo_rden_out;
    logic           src_fifo_empty_in;
    logic [DW-1:0]  src_fifo_data_in;
    logic [NP-1:0]  ref_rden_in;
    logic [NP*PW-1:0] ref_addr_in;
    logic [NP*DW-1:0] ref_data_out;
    logic [NP-1:0]  ref_valid_out;
    logic [1:0]     dbg_state;
    logic [AW-1:0]  dbg_load_cnt;

    dtw_core_ref_multi #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW), .NUM_PORTS(NP), .REF_INIT(1'b0)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rs_in(rs_in), .op_mode_in(op_mode_in),
        .ref_len_in(ref_len_in), .busy_out(busy_out), .ref_load_done_out(ref_load_done_out),
        .ref_len_err_out(ref_len_err_out), .src_fifo_clear_out(src_fifo_clear_out),
        .src_fifo_rden_out(src_fifo_rden_out), .src_fifo_empty_in(src_fifo_empty_in),
        .src_fifo_data_in(src_fifo_data_in), .ref_rden_in(ref_rden_in), .ref_addr_in(ref_addr_in),
        .ref_data_out(ref_data_out), .ref_valid_out(ref_valid_out), .dbg_state(dbg_state),
        .dbg_load_cnt(dbg_load_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NP-1:0]    rden;
        logic [NP*PW-1:0] addr;
        logic [NP*DW-1:0] data;
        logic [NP-1:0]    valid;
    } vec_t;

    vec_t          tbl [4];
    logic [DW-1:0] q [$];
    logic [DW-1:0] mem_m [64];
    logic [DW-1:0] exp_d [NP];
    logic [DW-1:0] w [64];
    int            hi;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic upd();
        src_fifo_empty_in = q.size() == 0;
        src_fifo_data_in  = q.size() != 0 ? q[0] : '0;
    endtask

    // Behavioural FWFT FIFO: pops on read enable, empties on clear.
    task automatic cyc();
        logic take, clr;
        #1;
        take = src_fifo_rden_out;
        clr  = src_fifo_clear_out;
        @(posedge clk_in);
        #1;
        if (clr) q.delete();
        else if (take && q.size() != 0) void'(q.pop_front());
        upd();
        #1;
    endtask

    task automatic apply(input string n, input vec_t v);
        ref_rden_in = v.rden;
        ref_addr_in = v.addr;
        cyc();
        chk({n, "_valid"}, 64'(ref_valid_out), 64'(v.valid));
        chk({n, "_data"}, 64'(ref_data_out), 64'(v.data));
        ref_rden_in = '0;
    endtask

    task automatic push(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) q.push_back(base + DW'(k));
        upd();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'hf, {6'd7, 6'd5, 6'd3, 6'd0}, {16'h8, 16'h6, 16'h4, 16'h1}, 4'hf};
        tbl[1] = '{4'ha, {6'd6, 6'd0, 6'd2, 6'd0}, {16'h7, 16'h6, 16'h3, 16'h1}, 4'ha};
        tbl[2] = '{4'h0, {6'd1, 6'd1, 6'd1, 6'd1}, {16'h7, 16'h6, 16'h3, 16'h1}, 4'h0};
        tbl[3] = '{4'hf, {6'd4, 6'd5, 6'd6, 6'd7}, {16'h5, 16'h6, 16'h7, 16'h8}, 4'hf};

        rst_n_in = 1'b0; rs_in = 1'b0; op_mode_in = 1'b0; ref_len_in = '0;
        ref_rden_in = '0; ref_addr_in = '0;
        upd();
        #22;
        chk("rst_state", 64'(dbg_state), 0);
        chk("rst_busy", 64'(busy_out), 0);
        chk("rst_clear", 64'(src_fifo_clear_out), 1);
        chk("rst_done", 64'(ref_load_done_out), 0);
        chk("rst_err", 64'(ref_len_err_out), 0);
        chk("rst_valid", 64'(ref_valid_out), 0);
        chk("rst_data", 64'(ref_data_out), 0);
        chk("rst_cnt", 64'(dbg_load_cnt), 0);
        rst_n_in = 1'b1;
        repeat (3) cyc();

        // Basic load of 1..8: eight back-to-back writes, IDLE after the last.
        rs_in = 1'b1; op_mode_in = 1'b1; ref_len_in = 8;
        cyc();
        chk("load_entry", 64'(dbg_state), 1);
        chk("load_busy", 64'(busy_out), 1);
        chk("load_clear", 64'(src_fifo_clear_out), 0);
        push(16'h1, 8);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("load_rden", 64'(src_fifo_rden_out), 1);
            cyc();
        end
        chk("load_idle", 64'(dbg_state), 0);
        chk("load_done", 64'(ref_load_done_out), 1);
        chk("load_cnt", 64'(dbg_load_cnt), 8);
        op_mode_in = 1'b0;
        cyc();
        chk("read_entry", 64'(dbg_state), 2);
        for (int k = 0; k < 4; k++) apply("tbl", tbl[k]);
        rs_in = 1'b0;
        cyc();
        chk("read_exit", 64'(dbg_state), 0);
        chk("done_kept", 64'(ref_load_done_out), 1);
        apply("idle_read", '{4'hf, 24'h0, {16'h5, 16'h6, 16'h7, 16'h8}, 4'h0});

        // FIFO stall after two words.
        rs_in = 1'b1; op_mode_in = 1'b1; ref_len_in = 4;
        cyc();
        push(16'ha1, 2);
        cyc(); cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rden", 64'(src_fifo_rden_out), 0);
            cyc();
            chk("stall_cnt", 64'(dbg_load_cnt), 2);
            chk("stall_state", 64'(dbg_state), 1);
        end
        push(16'ha3, 2);
        cyc(); cyc();
        chk("stall_done", 64'(ref_load_done_out), 1);
        chk("stall_idle", 64'(dbg_state), 0);
        op_mode_in = 1'b0;
        cyc();
        apply("stall_read", '{4'hf, {6'd3, 6'd2, 6'd1, 6'd0}, {16'ha4, 16'ha3, 16'ha2, 16'ha1}, 4'hf});
        rs_in = 1'b0;
        cyc();

        // Length errors and the largest legal length.
        rs_in = 1'b1; op_mode_in = 1'b1; ref_len_in = 0;
        cyc();
        chk("err0_state", 64'(dbg_state), 3);
        chk("err0_flag", 64'(ref_len_err_out), 1);
        chk("err0_clear", 64'(src_fifo_clear_out), 1);
        chk("err0_busy", 64'(busy_out), 1);
        cyc();
        chk("err0_hold", 64'(dbg_state), 3);
        rs_in = 1'b0;
        cyc();
        chk("err0_exit", 64'(dbg_state), 0);
        chk("err0_flagclr", 64'(ref_len_err_out), 0);
        rs_in = 1'b1; ref_len_in = 65;
        cyc();
        chk("err65_state", 64'(dbg_state), 3);
        chk("err65_flag", 64'(ref_len_err_out), 1);
        rs_in = 1'b0;
        cyc();
        rs_in = 1'b1; ref_len_in = 64;
        cyc();
        chk("len64_state", 64'(dbg_state), 1);
        chk("len64_doneclr", 64'(ref_load_done_out), 0);
        rs_in = 1'b0;
        cyc();

        // Abort after three of eight words; the aborting cycle writes nothing.
        rs_in = 1'b1; ref_len_in = 8;
        cyc();
        push(16'hb1, 8);
        repeat (3) cyc();
        chk("abort_cnt3", 64'(dbg_load_cnt), 3);
        rs_in = 1'b0;
        cyc();
        chk("abort_state", 64'(dbg_state), 0);
        chk("abort_done", 64'(ref_load_done_out), 0);
        chk("abort_cnt", 64'(dbg_load_cnt), 0);

        // Reset mid-load leaves a partial image behind.
        rs_in = 1'b1;
        cyc();
        push(16'hc1, 8);
        repeat (3) cyc();
        rst_n_in = 1'b0; rs_in = 1'b0;
        #1;
        chk("mrst_state", 64'(dbg_state), 0);
        chk("mrst_busy", 64'(busy_out), 0);
        chk("mrst_cnt", 64'(dbg_load_cnt), 0);
        chk("mrst_valid", 64'(ref_valid_out), 0);
        chk("mrst_data", 64'(ref_data_out), 0);
        chk("mrst_rden", 64'(src_fifo_rden_out), 0);
        rs_in = 1'b1; op_mode_in = 1'b1; ref_len_in = 2;
        rst_n_in = 1'b1;
        cyc();
        chk("sync_hold1", 64'(dbg_state), 0);
        cyc();
        chk("sync_hold2", 64'(dbg_state), 0);
        cyc();
        chk("sync_load", 64'(dbg_state), 1);
        push(16'hd1, 2);
        cyc(); cyc();
        chk("d_done", 64'(ref_load_done_out), 1);
        op_mode_in = 1'b0;
        cyc();
        apply("image_read", '{4'hf, {6'd3, 6'd2, 6'd1, 6'd0}, {16'ha4, 16'hc3, 16'hd2, 16'hd1}, 4'hf});

        // Randomized reload / read against a memory-image model.
        mem_m[0] = 16'hd1; mem_m[1] = 16'hd2; mem_m[2] = 16'hc3; mem_m[3] = 16'ha4;
        for (int k = 4; k < 8; k++) mem_m[k] = DW'(k + 1);
        hi = 8;
        exp_d[0] = 16'hd1; exp_d[1] = 16'hd2; exp_d[2] = 16'hc3; exp_d[3] = 16'ha4;
        for (int it = 0; it < 6; it++) begin
            int len, pushed;
            logic [NP-1:0] ev;
            len = $urandom_range(1, 64);
            for (int k = 0; k < len; k++) w[k] = DW'($urandom);
            ref_len_in = len;
            op_mode_in = 1'b1;
            cyc();
            chk("rl_idle", 64'(dbg_state), 0);
            chk("rl_done_kept", 64'(ref_load_done_out), 1);
            cyc();
            chk("rl_load", 64'(dbg_state), 1);
            chk("rl_done_clr", 64'(ref_load_done_out), 0);
            pushed = 0;
            for (int c = 0; c < 600 && !ref_load_done_out; c++) begin
                if (pushed < len && $urandom_range(0, 2) != 0) begin
                    q.push_back(w[pushed]);
                    pushed++;
                    upd();
                end
                cyc();
            end
            op_mode_in = 1'b0;
            chk("rl_done", 64'(ref_load_done_out), 1);
            chk("rl_cnt", 64'(dbg_load_cnt), 64'(len));
            for (int k = 0; k < len; k++) mem_m[k] = w[k];
            if (len > hi) hi = len;
            cyc();
            chk("rl_read", 64'(dbg_state), 2);
            for (int r = 0; r < 16; r++) begin
                ev = NP'($urandom);
                ref_rden_in = ev;
                for (int p = 0; p < NP; p++) begin
                    int a;
                    a = $urandom_range(0, hi - 1);
                    ref_addr_in[p*PW +: PW] = PW'(a);
                    if (ev[p]) exp_d[p] = mem_m[a];
                end
                cyc();
                chk("rd_valid", 64'(ref_valid_out), 64'(ev));
                for (int p = 0; p < NP; p++)
                    chk($sformatf("rd_data%0d", p), 64'(ref_data_out[p*DW +: DW]), 64'(exp_d[p]));
            end
            ref_rden_in = '0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
